// File: rtl/dmem_rr_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_rr_arbiter
//
// Round-robin arbiter that shares one single-port, word-addressed data-memory
// BRAM between NCORES harts. It also tracks one LR/SC reservation per hart for
// the RV32A LR.W / SC.W instructions.
//
// Each cycle at most one requesting hart is granted. The grant drives the BRAM
// in the same cycle. Harts that request but lose are stalled. A read or SC
// result is returned in the granted hart's rdata slot one cycle later.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   re_packed_i         per-hart read request (LR = read with is_lr)
//   we_packed_i         per-hart write request (SC = write with is_sc)
//   addr_packed_i       per-hart word address, slot r at [ADDRW*r +: ADDRW]
//   wdata_packed_i      per-hart write data, 32 bits per slot
//   wstrb_packed_i      per-hart byte strobes, 4 bits per slot
//   is_lr_packed_i      request is LR.W
//   is_sc_packed_i      request is SC.W
//   rdata_packed_o      per-hart read/SC result, valid the cycle after grant
//   stall_packed_o      per-hart stall (combinational)
//   mem_en_o            BRAM enable
//   mem_wstrb_o         BRAM byte write enables (0 = read)
//   mem_addr_o          BRAM word address
//   mem_wdata_o         BRAM write data
//   mem_rdata_i         BRAM read data, one-cycle registered latency
// ----------------------------------------------------------------------------
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 12
`endif

module dmem_rr_arbiter #(
    parameter int NCORES = 2,
    parameter int ADDRW  = `DMEM_ADDRW
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NCORES-1:0]        re_packed_i,
    input  logic [NCORES-1:0]        we_packed_i,
    input  logic [ADDRW*NCORES-1:0]  addr_packed_i,
    input  logic [32*NCORES-1:0]     wdata_packed_i,
    input  logic [4*NCORES-1:0]      wstrb_packed_i,
    input  logic [NCORES-1:0]        is_lr_packed_i,
    input  logic [NCORES-1:0]        is_sc_packed_i,
    output logic [32*NCORES-1:0]     rdata_packed_o,
    output logic [NCORES-1:0]        stall_packed_o,
    output logic                     mem_en_o,
    output logic [3:0]               mem_wstrb_o,
    output logic [ADDRW-1:0]         mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic [31:0]              mem_rdata_i
);

    localparam int PTRW = (NCORES > 1) ? $clog2(NCORES) : 1;

    // Registered state
    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic [PTRW-1:0]   gnt_q, gnt_d;
    logic              rd_q, rd_d;
    logic              sc_q, sc_d;
    logic              sc_fail_q, sc_fail_d;
    logic [NCORES-1:0] resv_valid_q, resv_valid_d;
    logic [ADDRW-1:0]  resv_addr_q [NCORES];
    logic [ADDRW-1:0]  resv_addr_d [NCORES];

    // Grant and the granted hart's request fields
    logic [NCORES-1:0] req;
    logic              gnt_valid;
    logic [PTRW-1:0]   gnt_idx;
    logic              g_re, g_we, g_lr, g_sc;
    logic [ADDRW-1:0]  g_addr;
    logic [31:0]       g_wdata;
    logic [3:0]        g_wstrb;
    logic              g_resv_valid;
    logic [ADDRW-1:0]  g_resv_addr;
    logic              sc_ok;
    logic              mem_write;
    logic [31:0]       resp_word;

    assign req = re_packed_i | we_packed_i;

    // Round-robin scan. Offsets are walked from the farthest to the nearest,
    // so the last match is the first requester at or after ptr_q.
    always_comb begin
        logic [PTRW:0] sum;
        // NOTE: every always_comb output gets a default first, so no path
        // leaves a value held and no latch is inferred.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_q} + (PTRW+1)'(i);
            if (sum >= (PTRW+1)'(NCORES)) begin
                sum = sum - (PTRW+1)'(NCORES);
            end
            if (req[sum[PTRW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = sum[PTRW-1:0];
            end
        end
        // While in reset nothing is granted, so every output falls to 0.
        if (rst_i) begin
            gnt_valid = 1'b0;
        end
    end

    // Select the granted hart's fields.
    always_comb begin
        g_re         = 1'b0;
        g_we         = 1'b0;
        g_lr         = 1'b0;
        g_sc         = 1'b0;
        g_addr       = '0;
        g_wdata      = '0;
        g_wstrb      = '0;
        g_resv_valid = 1'b0;
        g_resv_addr  = '0;
        for (int r = 0; r < NCORES; r++) begin
            if (gnt_idx == PTRW'(r)) begin
                g_re         = re_packed_i[r];
                g_we         = we_packed_i[r];
                g_lr         = is_lr_packed_i[r];
                g_sc         = is_sc_packed_i[r];
                g_addr       = addr_packed_i[ADDRW*r +: ADDRW];
                g_wdata      = wdata_packed_i[32*r +: 32];
                g_wstrb      = wstrb_packed_i[4*r +: 4];
                g_resv_valid = resv_valid_q[r];
                g_resv_addr  = resv_addr_q[r];
            end
        end
    end

    // A write request takes precedence over a read when both are raised.
    // A write goes to memory unless it is an SC that fails.
    assign sc_ok     = g_resv_valid && (g_resv_addr == g_addr);
    assign mem_write = gnt_valid && g_we && (!g_sc || sc_ok);

    assign mem_en_o    = gnt_valid;
    assign mem_addr_o  = gnt_valid ? g_addr  : '0;
    assign mem_wdata_o = gnt_valid ? g_wdata : '0;
    assign mem_wstrb_o = mem_write ? g_wstrb : 4'h0;

    always_comb begin
        stall_packed_o = '0;
        for (int r = 0; r < NCORES; r++) begin
            stall_packed_o[r] = !rst_i && req[r] && !(gnt_valid && gnt_idx == PTRW'(r));
        end
    end

    // Next state: pointer, response tags, reservations.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) begin
            ptr_d = (gnt_idx == PTRW'(NCORES - 1)) ? '0 : gnt_idx + PTRW'(1);
        end

        gnt_d     = gnt_idx;
        rd_d      = gnt_valid && g_re && !g_we;
        sc_d      = gnt_valid && g_we && g_sc;
        sc_fail_d = !sc_ok;

        for (int r = 0; r < NCORES; r++) begin
            resv_valid_d[r] = resv_valid_q[r];
            resv_addr_d[r]  = resv_addr_q[r];
            // A store to the reserved word breaks the reservation. Strobes
            // are ignored, and the writer's own reservation is included.
            if (mem_write && resv_addr_q[r] == g_addr) begin
                resv_valid_d[r] = 1'b0;
            end
            if (gnt_valid && gnt_idx == PTRW'(r)) begin
                if (g_we && g_sc) begin
                    resv_valid_d[r] = 1'b0;
                end
                // LR performs no write, so this set never races a clear
                // caused by the same grant.
                if (g_re && !g_we && g_lr) begin
                    resv_valid_d[r] = 1'b1;
                    resv_addr_d[r]  = g_addr;
                end
            end
        end
    end

    // Route the response to the slot granted last cycle.
    assign resp_word = rd_q ? mem_rdata_i : {31'b0, sc_fail_q};

    always_comb begin
        rdata_packed_o = '0;
        for (int r = 0; r < NCORES; r++) begin
            if (!rst_i && (rd_q || sc_q) && gnt_q == PTRW'(r)) begin
                rdata_packed_o[32*r +: 32] = resp_word;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so all flops
    // sample the values from before the clock edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q        <= '0;
            gnt_q        <= '0;
            rd_q         <= 1'b0;
            sc_q         <= 1'b0;
            sc_fail_q    <= 1'b0;
            resv_valid_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            rd_q         <= rd_d;
            sc_q         <= sc_d;
            sc_fail_q    <= sc_fail_d;
            resv_valid_q <= resv_valid_d;
        end
    end

    // NOTE: reservation addresses have no reset. They are only read while
    // their valid bit is set, and that bit is reset.
    always_ff @(posedge clk_i) begin
        resv_addr_q <= resv_addr_d;
    end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_rr_arbiter
//
// Self-checking bench for dmem_rr_arbiter with NCORES=2. A behavioural BRAM
// is attached to the memory port. A transaction-level reference model keeps a
// shadow memory, one reservation per hart, and the next hart to scan from.
// Every cycle it predicts stall, the memory command and the next-cycle rdata.
// Directed scenarios run first, then randomized traffic with occasional
// resets.
// ----------------------------------------------------------------------------
module tb_dmem_rr_arbiter;

    localparam int NC    = 2;
    localparam int ADDRW = 12;
    localparam int MEMW  = 1 << ADDRW;

    localparam int OP_IDLE  = 0;
    localparam int OP_READ  = 1;
    localparam int OP_LR    = 2;
    localparam int OP_WRITE = 3;
    localparam int OP_SC    = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NC-1:0]        re_t, we_t, lr_t, sc_t;
    logic [ADDRW-1:0]     addr_t  [NC];
    logic [31:0]          wdata_t [NC];
    logic [3:0]           wstrb_t [NC];

    logic [ADDRW*NC-1:0]  addr_packed;
    logic [32*NC-1:0]     wdata_packed;
    logic [4*NC-1:0]      wstrb_packed;
    logic [32*NC-1:0]     rdata_packed;
    logic [NC-1:0]        stall_packed;
    logic                 mem_en;
    logic [3:0]           mem_wstrb;
    logic [ADDRW-1:0]     mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0]      smem [MEMW];
    logic [31:0]      bram [MEMW];
    bit               m_resv_v [NC];
    int               m_resv_a [NC];
    int               m_start;
    logic [31:0]      m_resp [NC];
    logic [NC-1:0]    m_last_stall;

    always #5 clk = ~clk;

    for (genvar r = 0; r < NC; r++) begin : g_pack
        assign addr_packed[ADDRW*r +: ADDRW] = addr_t[r];
        assign wdata_packed[32*r +: 32]      = wdata_t[r];
        assign wstrb_packed[4*r +: 4]        = wstrb_t[r];
    end

    dmem_rr_arbiter #(.NCORES(NC), .ADDRW(ADDRW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .re_packed_i    (re_t),
        .we_packed_i    (we_t),
        .addr_packed_i  (addr_packed),
        .wdata_packed_i (wdata_packed),
        .wstrb_packed_i (wstrb_packed),
        .is_lr_packed_i (lr_t),
        .is_sc_packed_i (sc_t),
        .rdata_packed_o (rdata_packed),
        .stall_packed_o (stall_packed),
        .mem_en_o       (mem_en),
        .mem_wstrb_o    (mem_wstrb),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    // Behavioural single-port BRAM with registered read data
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= bram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic set_req(input int h, input int op, input int a,
                           input logic [31:0] d, input logic [3:0] s);
        re_t[h]    = (op == OP_READ)  || (op == OP_LR);
        we_t[h]    = (op == OP_WRITE) || (op == OP_SC);
        lr_t[h]    = (op == OP_LR);
        sc_t[h]    = (op == OP_SC);
        addr_t[h]  = ADDRW'(a);
        wdata_t[h] = d;
        wstrb_t[h] = s;
    endtask

    task automatic idle_all();
        for (int h = 0; h < NC; h++) set_req(h, OP_IDLE, 0, 32'h0, 4'h0);
    endtask

    // One clock cycle. The inputs are driven before the call, at the negedge.
    // The outputs are checked against the model. The model is advanced to the
    // next posedge, and the task returns at the following negedge.
    task automatic tick();
        int            g;
        int            h;
        bit            ok;
        logic [NC-1:0] exp_stall;
        logic [31:0]   new_resp [NC];
        #1;
        if (rst) begin
            for (int r = 0; r < NC; r++) check($sformatf("rst_rdata%0d", r), rdata_packed[32*r +: 32], 32'h0);
            check("rst_stall", 32'(stall_packed), 32'h0);
            check("rst_mem_en", 32'(mem_en), 32'h0);
            check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
            for (int r = 0; r < NC; r++) begin
                m_resv_v[r] = 1'b0;
                m_resp[r]   = 32'h0;
            end
            m_start      = 0;
            m_last_stall = '0;
        end else begin
            for (int r = 0; r < NC; r++) check($sformatf("rdata%0d", r), rdata_packed[32*r +: 32], m_resp[r]);
            g = -1;
            for (int i = 0; i < NC; i++) begin
                h = (m_start + i) % NC;
                if (g < 0 && (re_t[h] || we_t[h])) g = h;
            end
            for (int r = 0; r < NC; r++) begin
                exp_stall[r] = (re_t[r] || we_t[r]) && (r != g);
                new_resp[r]  = 32'h0;
            end
            check("stall", 32'(stall_packed), 32'(exp_stall));
            check("mem_en", 32'(mem_en), (g >= 0) ? 32'h1 : 32'h0);
            if (g >= 0) begin
                check("mem_addr", 32'(mem_addr), 32'(addr_t[g]));
                check("mem_wdata", mem_wdata, wdata_t[g]);
                if (we_t[g]) begin
                    ok = !sc_t[g] || (m_resv_v[g] && m_resv_a[g] == int'(addr_t[g]));
                    check("mem_wstrb", 32'(mem_wstrb), ok ? 32'(wstrb_t[g]) : 32'h0);
                    if (sc_t[g]) new_resp[g] = ok ? 32'h0 : 32'h1;
                    if (ok) begin
                        for (int r = 0; r < NC; r++)
                            if (m_resv_a[r] == int'(addr_t[g])) m_resv_v[r] = 1'b0;
                        for (int b = 0; b < 4; b++)
                            if (wstrb_t[g][b]) smem[addr_t[g]][8*b +: 8] = wdata_t[g][8*b +: 8];
                    end
                    if (sc_t[g]) m_resv_v[g] = 1'b0;
                end else begin
                    check("mem_wstrb_rd", 32'(mem_wstrb), 32'h0);
                    new_resp[g] = smem[addr_t[g]];
                    if (lr_t[g]) begin
                        m_resv_v[g] = 1'b1;
                        m_resv_a[g] = int'(addr_t[g]);
                    end
                end
                m_start = (g + 1) % NC;
            end
            for (int r = 0; r < NC; r++) m_resp[r] = new_resp[r];
            m_last_stall = exp_stall;
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MEMW; i++) begin
            smem[i] = 32'h0;
            bram[i] = 32'h0;
        end
        for (int r = 0; r < NC; r++) begin
            m_resv_v[r] = 1'b0;
            m_resv_a[r] = 0;
            m_resp[r]   = 32'h0;
        end
        m_start = 0;
        m_last_stall = '0;
        idle_all();
        rst = 1'b1;

        // Power-on reset, with one hart requesting to show the outputs held at 0
        set_req(1, OP_READ, 1, 32'h0, 4'h0);
        tick();
        tick();
        rst = 1'b0;
        idle_all();
        tick();

        // 1: write then read back on hart 0
        set_req(0, OP_WRITE, 5, 32'hDEADBEEF, 4'hF);
        #1 check("t1_wr_stall", 32'(stall_packed), 32'h0);
        tick();
        set_req(0, OP_READ, 5, 32'h0, 4'h0);
        tick();
        idle_all();
        check("t1_rdata", rdata_packed[31:0], 32'hDEADBEEF);
        tick();

        // 2: both harts read continuously from reset, so grants alternate
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, OP_READ, 1, 32'h0, 4'h0);
        set_req(1, OP_READ, 2, 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            #1 check($sformatf("t2_stall_%0d", k), 32'(stall_packed), (k % 2 == 0) ? 32'h2 : 32'h1);
            tick();
        end
        idle_all();
        tick();

        // 3: LR then SC succeeds and writes; a second SC fails
        set_req(0, OP_LR, 8, 32'h0, 4'h0);
        tick();
        set_req(0, OP_SC, 8, 32'h7, 4'hF);
        #1 check("t3_sc_wstrb", 32'(mem_wstrb), 32'hF);
        tick();
        check("t3_sc_ok", rdata_packed[31:0], 32'h0);
        set_req(0, OP_READ, 8, 32'h0, 4'h0);
        tick();
        check("t3_mem8", rdata_packed[31:0], 32'h7);
        set_req(0, OP_SC, 8, 32'h9, 4'hF);
        #1 check("t3_sc2_wstrb", 32'(mem_wstrb), 32'h0);
        tick();
        check("t3_sc2_fail", rdata_packed[31:0], 32'h1);
        idle_all();

        // 4: another hart's write to the reserved word breaks the reservation
        set_req(0, OP_LR, 8, 32'h0, 4'h0);
        tick();
        idle_all();
        set_req(1, OP_WRITE, 8, 32'h55, 4'h1);
        tick();
        idle_all();
        set_req(0, OP_SC, 8, 32'h11, 4'hF);
        #1 check("t4_sc_wstrb", 32'(mem_wstrb), 32'h0);
        tick();
        check("t4_sc_fail", rdata_packed[31:0], 32'h1);
        set_req(0, OP_LR, 8, 32'h0, 4'h0);
        tick();
        idle_all();
        set_req(1, OP_WRITE, 9, 32'h66, 4'hF);
        tick();
        idle_all();
        set_req(0, OP_SC, 8, 32'h12, 4'hF);
        tick();
        check("t4_sc_ok", rdata_packed[31:0], 32'h0);
        idle_all();

        // 5: a failed SC by hart 1 leaves hart 0's reservation intact
        set_req(0, OP_LR, 3, 32'h0, 4'h0);
        tick();
        idle_all();
        set_req(1, OP_SC, 3, 32'h33, 4'hF);
        tick();
        check("t5_h1_fail", rdata_packed[63:32], 32'h1);
        idle_all();
        set_req(0, OP_SC, 3, 32'h44, 4'hF);
        tick();
        check("t5_h0_ok", rdata_packed[31:0], 32'h0);
        idle_all();

        // 6: reset mid-traffic drops the reservation and restarts the scan at hart 0
        set_req(0, OP_LR, 4, 32'h0, 4'h0);
        tick();
        set_req(0, OP_READ, 6, 32'h0, 4'h0);
        set_req(1, OP_READ, 7, 32'h0, 4'h0);
        tick();
        rst = 1'b1;
        #1 check("t6_rst_stall", 32'(stall_packed), 32'h0);
        check("t6_rst_en", 32'(mem_en), 32'h0);
        tick();
        rst = 1'b0;
        #1 check("t6_first_gnt", 32'(stall_packed), 32'h2);
        tick();
        set_req(0, OP_IDLE, 0, 32'h0, 4'h0);
        tick();
        set_req(0, OP_SC, 4, 32'h77, 4'hF);
        set_req(1, OP_IDLE, 0, 32'h0, 4'h0);
        tick();
        check("t6_sc_fail", rdata_packed[31:0], 32'h1);
        idle_all();
        tick();

        // Randomized traffic. A stalled hart holds its request unchanged.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int h = 0; h < NC; h++) begin
                if (!m_last_stall[h]) begin
                    set_req(h, $urandom_range(0, 5) % 5, $urandom_range(0, 7),
                            $urandom, 4'($urandom_range(1, 15)));
                end
            end
            tick();
        end
        rst = 1'b0;
        idle_all();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port, word-addressed data-memory BRAM port between NCORES harts.
- Implements LR/SC reservation tracking for the RV32A atomics used by multi-hart software.
- Sits between the per-hart packed dbus signals (dmem range, already address-decoded) and the BRAM.
- Grants one access per cycle, stalls losing harts, and returns read/SC results one cycle after grant.

Parameters:
- NCORES, 2, number of requesting harts (1..8).
- ADDRW, `DMEM_ADDRW (12), word-address width of the data memory.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- re_packed_i  in  NCORES  per-hart read request (LR is a read with is_lr=1).
- we_packed_i  in  NCORES  per-hart write request (SC is a write with is_sc=1).
- addr_packed_i  in  ADDRW*NCORES  per-hart word address; slot r at [ADDRW*r +: ADDRW].
- wdata_packed_i  in  32*NCORES  per-hart write data.
- wstrb_packed_i  in  4*NCORES  per-hart byte strobes.
- is_lr_packed_i  in  NCORES  request is LR.W.
- is_sc_packed_i  in  NCORES  request is SC.W.
- rdata_packed_o  out  32*NCORES  per-hart read/SC result, valid the cycle after grant.
- stall_packed_o  out  NCORES  per-hart stall; combinational.
- mem_en_o  out  1  BRAM enable.
- mem_wstrb_o  out  4  BRAM byte write enables (0 = read).
- mem_addr_o  out  ADDRW  BRAM word address.
- mem_wdata_o  out  32  BRAM write data.
- mem_rdata_i  in  32  BRAM read data, 1-cycle registered latency.

Behaviour:
- **Reset.**
  - Clears the rr pointer to 0, all reservations (valid=0), gnt_q/rd_q/sc_q.
  - While rst_i=1, all outputs are 0: rdata_packed_o=0, stall_packed_o=0, mem_en_o=0, mem_wstrb_o=0.
- **Request.** req[r] = re[r] | we[r]. Harts hold request fields stable while stall[r]=1.
- **Grant (combinational).**
  - The first r with req[r]=1, scanning ptr, ptr+1, … mod NCORES.
  - stall[g]=0 for the granted hart; stall[r]=1 for every other requesting r; stall=0 for non-requesting harts.
- **Pointer.** On a grant, ptr <= (g+1) mod NCORES; with no request, ptr holds.
- **Memory issue (same cycle as grant).**
  - mem_en_o=1, mem_addr_o=addr[g], mem_wdata_o=wdata[g].
  - mem_wstrb_o = wstrb[g] for a plain write, wstrb[g] for a successful SC, 0 for a failed SC or a read.
- **Response (cycle T+1).**
  - gnt_q, rd_q and sc_q are registered at T.
  - Slot gnt_q of rdata_packed_o = mem_rdata_i if rd_q; = {31'b0, sc_fail_q} if sc_q (0=success, 1=fail).
  - All other slots are 0. A plain write returns 0.
- **Reservations (one per hart: valid bit + ADDRW address).**
  - Granted LR by r: resv[r] <= {1, addr}.
  - Granted SC by r: success iff resv[r].valid and resv[r].addr == addr. resv[r].valid <= 0 regardless of outcome.
  - Any granted write that reaches memory (plain write or successful SC) to address A clears every reservation with addr == A, including the writer's own. This is word granularity and ignores strobes.
  - LR and a conflicting write cannot coincide, because there is one grant per cycle. When a same-cycle clear and set target the same hart, the set wins; this arises only for LR by that hart, which performs no write.
  - A failed SC clears no other hart's reservation.
- **Throughput.** 1 access per cycle. Worst-case wait is NCORES-1 cycles (starvation-free).
- **Re-grant.** A hart asserting req continuously is re-granted every cycle only when no other hart requests.
- **Reset mid-operation.** A pending response is dropped, pending reservations are lost, and the next grant after reset scans from hart 0.

Test Plan:
1. Single hart 0 writes 0xDEADBEEF, wstrb=0xF, to addr 5 at T, then reads addr 5 at T+1 → no stall; rdata slot0 = 0xDEADBEEF at T+2.
2. NCORES=2, both harts read continuously from reset → grants alternate 0,1,0,1; each hart is stalled every other cycle; each rdata lands only in the granted hart's slot.
3. Hart 0 LR addr 8, then hart 0 SC addr 8 with wdata=7 → SC result 0; mem_wstrb_o=0xF; memory[8]=7; reservation cleared; a second SC returns 1 with mem_wstrb_o=0.
4. Hart 0 LR addr 8, hart 1 writes addr 8, then hart 0 SC addr 8 → SC returns 1, no write issued. The same sequence with hart 1 writing addr 9 → SC returns 0.
5. Hart 0 LR addr 3, hart 1 SC addr 3 without its own LR → hart 1 gets 1; hart 0's reservation survives, so hart 0's subsequent SC to 3 returns 0.
6. Assert rst_i for 1 cycle while both harts request → stall_packed_o=0 and mem_en_o=0 during reset. After reset, the first grant goes to hart 0 and all reservations are invalid (an SC returns 1).
